debug_mem: RTL and testbench

- Debug-module memory slave for the hart-side debug window (4 KiB, decoded on addr_i[11:0]).
- Serves three things to harts running debug code:
  - the debug ROM image;
  - a parametrised program buffer and abstract data registers;
  - per-hart go/resume flag bytes.
- Captures hart handshake writes (HALTED/GOING/RESUMING/EXCEPTION) and reports them to the debug-module control logic.
- Successor to the fixed single-hart ROM: multi-hart, sized by parameter, with a registered bus response and write support.

---
 rtl/debug_mem_if.sv | 22 ++
 rtl/debug_mem.sv | 189 ++++++++++++++++++
 tb/tb_debug_mem.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_mem_if.sv
// Hart-side bus of the debug memory window.
// Request/grant handshake with a response registered one cycle after acceptance.
interface debug_mem_if;
    logic        req_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o
    );

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/debug_mem.sv
// Debug-module memory slave: ROM image, program buffer, data registers and per-hart
// go/resume flags in a 4 KiB window, plus capture of the hart halt/resume handshake.
module debug_mem #(
    parameter int NrHarts     = 1,
    parameter int ProgBufSize = 8,
    parameter int DataCount   = 2,
    parameter int RomSize     = 38,
    parameter int HW          = (NrHarts > 1) ? $clog2(NrHarts) : 1,
    parameter logic [RomSize-1:0][31:0] RomInit = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    debug_mem_if.slave                 bus,
    input  logic                       cmd_go_i,
    input  logic                       resume_req_i,
    input  logic [HW-1:0]              hartsel_i,
    input  logic                       dm_we_i,
    input  logic [4:0]                 dm_addr_i,
    input  logic [31:0]                dm_wdata_i,
    output logic [NrHarts-1:0]         halted_o,
    output logic [NrHarts-1:0]         resumeack_o,
    output logic                       cmd_busy_o,
    output logic                       cmd_exc_o,
    output logic [ProgBufSize*32-1:0]  progbuf_o,
    output logic [DataCount*32-1:0]    data_o
);

    // Word offsets within the window (byte offset >> 2)
    localparam logic [9:0] WordHalted   = 10'h040;
    localparam logic [9:0] WordGoing    = 10'h041;
    localparam logic [9:0] WordResuming = 10'h042;
    localparam logic [9:0] WordExc      = 10'h043;
    localparam logic [9:0] ProgBase     = 10'h0D8;
    localparam logic [9:0] DataBase     = 10'h0E0;
    localparam logic [9:0] FlagBase     = 10'h100;
    localparam logic [9:0] RomBase      = 10'h200;

    logic [9:0]  word;
    logic        wr;
    logic        addr_unused;

    assign word        = bus.addr_i[11:2];
    assign wr          = bus.req_i & bus.we_i;
    assign addr_unused = ^{bus.addr_i[31:12], bus.addr_i[1:0]};
    assign bus.gnt_o   = bus.req_i;

    logic [ProgBufSize-1:0][31:0] prog_q, prog_d;
    logic [DataCount-1:0][31:0]   data_q, data_d;
    logic [NrHarts-1:0]           go_q, go_d;
    logic [NrHarts-1:0]           resume_q, resume_d;
    logic [NrHarts-1:0]           halted_q, halted_d;
    logic [NrHarts-1:0]           rack_q, rack_d;
    logic                         busy_q, busy_d;
    logic                         exc_q;
    logic                         vld_p1;
    logic [9:0]                   addr_p1;
    logic [31:0]                  rdata;

    // Data registers take precedence if a large program buffer runs into them
    logic data_hit;
    always_comb begin
        data_hit = 1'b0;
        for (int i = 0; i < DataCount; i++) begin
            if (word == DataBase + 10'(i)) data_hit = 1'b1;
        end
    end

    // DM writes land first as full words; enabled bus bytes then override them
    always_comb begin
        prog_d = prog_q;
        data_d = data_q;
        for (int i = 0; i < ProgBufSize; i++) begin
            if (dm_we_i && dm_addr_i == 5'(i)) prog_d[i] = dm_wdata_i;
            if (wr && !data_hit && word == ProgBase + 10'(i)) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.be_i[b]) prog_d[i][8*b +: 8] = bus.wdata_i[8*b +: 8];
                end
            end
        end
        for (int i = 0; i < DataCount; i++) begin
            if (dm_we_i && dm_addr_i == 5'(16 + i)) data_d[i] = dm_wdata_i;
            if (wr && word == DataBase + 10'(i)) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.be_i[b]) data_d[i][8*b +: 8] = bus.wdata_i[8*b +: 8];
                end
            end
        end
    end

    logic [HW-1:0] hs_id;
    logic          hs_ok;
    logic          sel_ok;
    logic          halted_we;
    logic          going_we;
    logic          resuming_we;
    logic          exc_we;
    logic          go_ok;

    assign hs_id       = bus.wdata_i[HW-1:0];
    assign hs_ok       = 32'(hs_id) < 32'(NrHarts);
    assign sel_ok      = 32'(hartsel_i) < 32'(NrHarts);
    assign halted_we   = wr && word == WordHalted && hs_ok;
    assign going_we    = wr && word == WordGoing;
    assign resuming_we = wr && word == WordResuming && hs_ok;
    assign exc_we      = wr && word == WordExc;
    assign go_ok       = cmd_go_i && !busy_q && sel_ok;

    // DM-side requests are applied last so they win over same-cycle hart writes
    always_comb begin
        go_d     = go_q;
        resume_d = resume_q;
        halted_d = halted_q;
        rack_d   = rack_q;
        busy_d   = busy_q;
        if (going_we) go_d = '0;
        if (halted_we) begin
            halted_d[hs_id] = 1'b1;
            resume_d[hs_id] = 1'b0;
        end
        if (resuming_we) begin
            halted_d[hs_id] = 1'b0;
            rack_d[hs_id]   = 1'b1;
            resume_d[hs_id] = 1'b0;
        end
        if (halted_we || exc_we) busy_d = 1'b0;
        if (resume_req_i && sel_ok) begin
            resume_d[hartsel_i] = 1'b1;
            rack_d[hartsel_i]   = 1'b0;
        end
        if (go_ok) begin
            go_d[hartsel_i] = 1'b1;
            busy_d          = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1   <= 1'b0;
            addr_p1  <= '0;
            prog_q   <= '0;
            data_q   <= '0;
            go_q     <= '0;
            resume_q <= '0;
            halted_q <= '0;
            rack_q   <= '0;
            busy_q   <= 1'b0;
            exc_q    <= 1'b0;
        end else begin
            vld_p1   <= bus.req_i;
            if (bus.req_i) addr_p1 <= word;
            prog_q   <= prog_d;
            data_q   <= data_d;
            go_q     <= go_d;
            resume_q <= resume_d;
            halted_q <= halted_d;
            rack_q   <= rack_d;
            busy_q   <= busy_d;
            exc_q    <= exc_we;
        end
    end

    // ---- response stage: decode the registered address against current storage ----
    always_comb begin
        rdata = '0;
        for (int i = 0; i < RomSize; i++) begin
            if (addr_p1 == RomBase + 10'(i)) rdata = RomInit[i];
        end
        for (int i = 0; i < ProgBufSize; i++) begin
            if (addr_p1 == ProgBase + 10'(i)) rdata = prog_q[i];
        end
        for (int i = 0; i < DataCount; i++) begin
            if (addr_p1 == DataBase + 10'(i)) rdata = data_q[i];
        end
        for (int h = 0; h < NrHarts; h++) begin
            if (addr_p1 == FlagBase + 10'(h / 4)) rdata[8*(h % 4) +: 2] = {resume_q[h], go_q[h]};
        end
    end

    assign bus.rvalid_o = vld_p1;
    assign bus.rdata_o  = vld_p1 ? rdata : '0;

    assign halted_o    = halted_q;
    assign resumeack_o = rack_q;
    assign cmd_busy_o  = busy_q;
    assign cmd_exc_o   = exc_q;
    assign progbuf_o   = prog_q;
    assign data_o      = data_q;

endmodule

// File: tb/tb_debug_mem.sv
// Bench for debug_mem: directed handshake/merge/reset scenarios plus random traffic,
// all checked each cycle against a behavioural model of the memory map.
module tb_debug_mem;
    localparam int NH = 4;
    localparam int PB = 8;
    localparam int DC = 2;
    localparam int RS = 38;

    function automatic logic [RS-1:0][31:0] mk_rom();
        logic [RS-1:0][31:0] r;
        r[0] = 32'h00c0006f;
        for (int i = 1; i < RS; i++) r[i] = {8'hC3, 8'(i), 16'(i * 37 + 5)};
        return r;
    endfunction

    localparam logic [RS-1:0][31:0] ROM = mk_rom();

    logic              clk;
    logic              rst_n;
    logic              cmd_go;
    logic              resume_req;
    logic [1:0]        hartsel;
    logic              dm_we;
    logic [4:0]        dm_addr;
    logic [31:0]       dm_wdata;
    logic [NH-1:0]     halted;
    logic [NH-1:0]     resumeack;
    logic              cmd_busy;
    logic              cmd_exc;
    logic [PB*32-1:0]  progbuf;
    logic [DC*32-1:0]  data;

    debug_mem_if bus();

    debug_mem #(
        .NrHarts(NH), .ProgBufSize(PB), .DataCount(DC), .RomSize(RS), .RomInit(ROM)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus),
        .cmd_go_i(cmd_go), .resume_req_i(resume_req), .hartsel_i(hartsel),
        .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .halted_o(halted), .resumeack_o(resumeack), .cmd_busy_o(cmd_busy),
        .cmd_exc_o(cmd_exc), .progbuf_o(progbuf), .data_o(data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // Behavioural model of the visible state
    logic [31:0]   m_prog [PB];
    logic [31:0]   m_data [DC];
    logic [NH-1:0] m_go, m_res, m_halt, m_rack;
    logic          m_busy, m_exc, e_rvalid;
    logic [31:0]   e_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < PB; i++) m_prog[i] = '0;
        for (int i = 0; i < DC; i++) m_data[i] = '0;
        m_go = '0; m_res = '0; m_halt = '0; m_rack = '0;
        m_busy = 1'b0; m_exc = 1'b0; e_rvalid = 1'b0; e_addr = '0;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int off;
        logic [31:0] r;
        off = int'(a[11:0]) & ~3;
        r = '0;
        if (off >= 'h800 && (off - 'h800) / 4 < RS) return ROM[(off - 'h800) / 4];
        if (off >= 'h380 && (off - 'h380) / 4 < DC) return m_data[(off - 'h380) / 4];
        if (off >= 'h360 && (off - 'h360) / 4 < PB) return m_prog[(off - 'h360) / 4];
        for (int h = 0; h < NH; h++) begin
            if (off == 'h400 + 4 * (h / 4)) begin
                r[8 * (h % 4)]     = m_go[h];
                r[8 * (h % 4) + 1] = m_res[h];
            end
        end
        return r;
    endfunction

    // Apply one clock edge's worth of inputs to the model
    task automatic model_edge();
        logic wr, old_busy;
        int off, da, id;
        logic [31:0] mask;
        if (!rst_n) begin
            model_reset();
            return;
        end
        wr = bus.req_i && bus.we_i;
        off = int'(bus.addr_i[11:0]) & ~3;
        id = int'(bus.wdata_i[1:0]);
        da = int'(dm_addr);
        old_busy = m_busy;
        e_rvalid = bus.req_i;
        e_addr = bus.addr_i;
        m_exc = wr && off == 'h10C;
        mask = {{8{bus.be_i[3]}}, {8{bus.be_i[2]}}, {8{bus.be_i[1]}}, {8{bus.be_i[0]}}};
        if (dm_we) begin
            if (da < PB) m_prog[da] = dm_wdata;
            else if (da >= 16 && da < 16 + DC) m_data[da - 16] = dm_wdata;
        end
        if (wr) begin
            if (off >= 'h380 && (off - 'h380) / 4 < DC)
                m_data[(off - 'h380) / 4] = (m_data[(off - 'h380) / 4] & ~mask) | (bus.wdata_i & mask);
            else if (off >= 'h360 && (off - 'h360) / 4 < PB)
                m_prog[(off - 'h360) / 4] = (m_prog[(off - 'h360) / 4] & ~mask) | (bus.wdata_i & mask);
        end
        if (wr && off == 'h104) m_go = '0;
        if (wr && off == 'h100) begin m_halt[id] = 1'b1; m_res[id] = 1'b0; m_busy = 1'b0; end
        if (wr && off == 'h10C) m_busy = 1'b0;
        if (wr && off == 'h108) begin m_halt[id] = 1'b0; m_rack[id] = 1'b1; m_res[id] = 1'b0; end
        if (resume_req) begin m_res[hartsel] = 1'b1; m_rack[hartsel] = 1'b0; end
        if (cmd_go && !old_busy) begin m_go[hartsel] = 1'b1; m_busy = 1'b1; end
    endtask

    task automatic compare();
        check("gnt", 32'(bus.gnt_o), 32'(bus.req_i));
        check("rvalid", 32'(bus.rvalid_o), 32'(e_rvalid));
        if (e_rvalid) check("rdata", bus.rdata_o, m_read(e_addr));
        check("halted", 32'(halted), 32'(m_halt));
        check("resumeack", 32'(resumeack), 32'(m_rack));
        check("cmd_busy", 32'(cmd_busy), 32'(m_busy));
        check("cmd_exc", 32'(cmd_exc), 32'(m_exc));
        for (int i = 0; i < PB; i++) check($sformatf("progbuf%0d", i), progbuf[32*i +: 32], m_prog[i]);
        for (int i = 0; i < DC; i++) check($sformatf("data%0d", i), data[32*i +: 32], m_data[i]);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic idle();
        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.be_i = 4'h0; bus.addr_i = '0; bus.wdata_i = '0;
        cmd_go = 1'b0; resume_req = 1'b0; hartsel = '0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    endtask

    task automatic bus_op(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        bus.req_i = 1'b1; bus.we_i = w; bus.addr_i = a; bus.wdata_i = d; bus.be_i = b;
        cycle();
        idle();
    endtask

    task automatic rd_expect(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus_op(1'b0, a, '0, 4'h0);
        check(name, bus.rdata_o, exp);
    endtask

    initial begin
        logic [31:0] r;
        idle();
        model_reset();
        rst_n = 1'b0;
        repeat (3) cycle();
        check("rst_rvalid", 32'(bus.rvalid_o), 32'h0);
        check("rst_rdata", bus.rdata_o, 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_busy", 32'(cmd_busy), 32'h0);
        rst_n = 1'b1;
        cycle();

        rd_expect("rom0", 32'h800, 32'h00c0006f);
        check("rom0_valid", 32'(bus.rvalid_o), 32'h1);
        rd_expect("rom_past_end", 32'h800 + 4 * RS, 32'h0);

        cmd_go = 1'b1; hartsel = 2'd2; cycle(); idle();
        check("go_busy", 32'(cmd_busy), 32'h1);
        rd_expect("flag_go2", 32'h400, 32'h00010000);
        bus_op(1'b1, 32'h104, 32'h0, 4'hF);
        rd_expect("flag_after_going", 32'h400, 32'h0);
        bus_op(1'b1, 32'h100, 32'd2, 4'hF);
        check("halted2", 32'(halted), 32'h4);
        check("busy_after_halt", 32'(cmd_busy), 32'h0);

        resume_req = 1'b1; hartsel = 2'd1; cycle(); idle();
        rd_expect("flag_res1", 32'h400, 32'h00000200);
        bus_op(1'b1, 32'h108, 32'd1, 4'hF);
        check("rack1", 32'(resumeack[1]), 32'h1);
        check("halted1", 32'(halted[1]), 32'h0);
        rd_expect("flag_after_resuming", 32'h400, 32'h0);

        dm_we = 1'b1; dm_addr = 5'd0; dm_wdata = 32'h11223344; cycle(); idle();
        bus_op(1'b1, 32'h360, 32'hAABBCCDD, 4'b0011);
        rd_expect("be_merge", 32'h360, 32'h1122CCDD);
        dm_we = 1'b1; dm_addr = 5'd0; dm_wdata = 32'hFFFFFFFF;
        bus_op(1'b1, 32'h360, 32'hAABBCCDD, 4'b0011);
        rd_expect("bus_dm_merge", 32'h360, 32'hFFFFCCDD);

        cmd_go = 1'b1; hartsel = 2'd0; cycle(); idle();
        cmd_go = 1'b1; hartsel = 2'd3; cycle(); idle();
        rd_expect("go_ignored_busy", 32'h400, 32'h00000001);
        bus_op(1'b1, 32'h10C, 32'h0, 4'hF);
        check("exc_pulse", 32'(cmd_exc), 32'h1);
        check("exc_busy", 32'(cmd_busy), 32'h0);
        cycle();
        check("exc_end", 32'(cmd_exc), 32'h0);

        bus_op(1'b1, 32'h100, 32'd3, 4'hF);
        check("halted23", 32'(halted), 32'hC);
        bus_op(1'b0, 32'h800, 32'h0, 4'h0);
        check("pre_rst_valid", 32'(bus.rvalid_o), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rvalid", 32'(bus.rvalid_o), 32'h0);
        check("async_halted", 32'(halted), 32'h0);
        model_reset();
        repeat (2) cycle();
        rst_n = 1'b1;
        rd_expect("prog_after_rst", 32'h360, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            idle();
            if ($urandom_range(0, 3) != 0) begin
                bus.req_i = 1'b1;
                bus.we_i = 1'($urandom_range(0, 1));
                bus.be_i = 4'($urandom_range(0, 15));
                bus.wdata_i = $urandom;
                case ($urandom_range(0, 7))
                    0: bus.addr_i = 32'h100 + 4 * $urandom_range(0, 3);
                    1: bus.addr_i = 32'h360 + 4 * $urandom_range(0, 9);
                    2: bus.addr_i = 32'h380 + 4 * $urandom_range(0, 3);
                    3: bus.addr_i = 32'h400 + 4 * $urandom_range(0, 1);
                    4, 5: bus.addr_i = 32'h800 + 4 * $urandom_range(0, RS + 1);
                    default: begin r = $urandom; bus.addr_i = r; end
                endcase
            end
            cmd_go = ($urandom_range(0, 7) == 0);
            resume_req = ($urandom_range(0, 7) == 0);
            hartsel = 2'($urandom_range(0, 3));
            dm_we = ($urandom_range(0, 3) == 0);
            dm_addr = 5'($urandom_range(0, 31));
            dm_wdata = $urandom;
            cycle();
        end
        idle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
